// File: rtl/pe_cfg_loader_pkg.sv
// Shared widths, state encodings and helpers for the PE configuration loader.
// State codes live here so benches and debug logic can decode the FSM.
package pe_cfg_loader_pkg;

  localparam int PE_NUM       = 16;
  localparam int PE_INST_W    = 48;
  localparam int BUFFER_DEPTH = 32;
  localparam int RUN_LEN_W    = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic ctx_in_range(
    input int unsigned n,
    input int unsigned depth
  );
    return (n >= 1) && (n <= depth);
  endfunction

endpackage

// File: rtl/pe_cfg_loader_checksum.sv
// Running XOR of accepted instruction words plus compare against a
// trailing checksum word. Used only when PE_CFG_CHECKSUM_EN is defined.
module pe_cfg_loader_checksum
  import pe_cfg_loader_pkg::*;
#(
  parameter int INST_W = PE_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc_en,
  input  logic [INST_W-1:0] data,
  output logic              match
);

  logic [INST_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc ^ data;
    end
  end

  assign match = (acc == data);

endmodule

// File: rtl/pe_cfg_loader.sv
// Configuration master for the PE array: clear, load per-PE contexts, run.
// Optional trailing checksum word check when PE_CFG_CHECKSUM_EN is defined.
module pe_cfg_loader
  import pe_cfg_loader_pkg::*;
#(
  parameter int NUM_PE = PE_NUM,
  parameter int INST_W = PE_INST_W,
  parameter int DEPTH  = BUFFER_DEPTH,
  parameter int RUN_W  = RUN_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(DEPTH):0] num_ctx,
  input  logic [RUN_W-1:0]       run_len,
  input  logic [INST_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   pe_rst,
  output logic [INST_W-1:0]      pe_inst,
  output logic [NUM_PE-1:0]      pe_init,
  output logic                   pe_run,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int NW    = $clog2(DEPTH) + 1;
  localparam int CTX_W = NW - 1;
  localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [NW-1:0]    nctx_q;
  logic [RUN_W-1:0] rlen_q;
  logic [RUN_W-1:0] run_cnt;
  logic [CTX_W-1:0] ctx_idx;
  logic [PE_W-1:0]  pe_idx;
  logic             xfer;
  logic             start_ok;
  logic             ctx_last;
  logic             pe_last;
  logic             word_last;
  logic             run_last;
  logic             chk_err;
  logic [2:0]       post_load;

`ifdef PE_CFG_CHECKSUM_EN
  logic chk_match;

  pe_cfg_loader_checksum #(
    .INST_W(INST_W)
  ) u_checksum (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == ST_CLEAR),
    .acc_en(state == ST_LOAD && xfer),
    .data  (s_data),
    .match (chk_match)
  );

  assign s_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign chk_err = (state == ST_CHECK) && xfer && !chk_match;
`else
  assign s_ready = (state == ST_LOAD);
  assign chk_err = 1'b0;
`endif

  assign xfer      = s_valid && s_ready;
  assign start_ok  = ctx_in_range(32'(num_ctx), DEPTH);
  assign ctx_last  = ({1'b0, ctx_idx} == nctx_q - NW'(1));
  assign pe_last   = (pe_idx == PE_W'(NUM_PE - 1));
  assign word_last = ctx_last && pe_last;
  assign run_last  = (run_cnt == rlen_q - RUN_W'(1));
  assign post_load = (rlen_q == '0) ? ST_DONE : ST_RUN;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start && start_ok) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
`ifdef PE_CFG_CHECKSUM_EN
        if (xfer && word_last) state_nxt = ST_CHECK;
`else
        if (xfer && word_last) state_nxt = post_load;
`endif
      end
`ifdef PE_CFG_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) state_nxt = chk_match ? post_load : ST_IDLE;
      end
`endif
      ST_RUN: begin
        if (run_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      pe_rst <= 1'b0;
      pe_run <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != ST_IDLE);
      pe_rst <= (state == ST_CLEAR);
      pe_run <= (state == ST_RUN);
      done   <= (state == ST_DONE);
      err    <= (state == ST_IDLE && start && !start_ok) || chk_err;
    end
  end

  // Latched sequence parameters; start outside IDLE leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      nctx_q <= '0;
      rlen_q <= '0;
    end else if (state == ST_IDLE && start && start_ok) begin
      nctx_q <= num_ctx;
      rlen_q <= run_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_idx <= '0;
      pe_idx  <= '0;
      pe_inst <= '0;
      pe_init <= '0;
    end else begin
      pe_init <= '0;
      if (state == ST_CLEAR) begin
        ctx_idx <= '0;
        pe_idx  <= '0;
      end else if (state == ST_LOAD && xfer) begin
        pe_inst <= s_data;
        pe_init <= NUM_PE'(1) << pe_idx;
        if (ctx_last) begin
          ctx_idx <= '0;
          if (!pe_last) pe_idx <= pe_idx + PE_W'(1);
        end else begin
          ctx_idx <= ctx_idx + CTX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      run_cnt <= '0;
    end else if (state == ST_RUN) begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Randomized bench for pe_cfg_loader against a transaction-level model.
// Define PE_CFG_CHECKSUM_EN for both bench and RTL to cover the checksum word.
module tb_pe_cfg_loader;

  localparam int NPE = 4;
  localparam int IW  = 48;
  localparam int DEP = 32;
  localparam int RW  = 16;
  localparam int NW  = $clog2(DEP) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] num_ctx;
  logic [RW-1:0] run_len;
  logic [IW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          pe_rst;
  logic [IW-1:0] pe_inst;
  logic [NPE-1:0] pe_init;
  logic          pe_run;
  logic          busy;
  logic          done;
  logic          err;

  pe_cfg_loader #(
    .NUM_PE(NPE),
    .INST_W(IW),
    .DEPTH (DEP),
    .RUN_W (RW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .num_ctx(num_ctx),
    .run_len(run_len),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .pe_rst (pe_rst),
    .pe_inst(pe_inst),
    .pe_init(pe_init),
    .pe_run (pe_run),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: everything observed on the PE side since the last clear.
  logic [NPE+IW-1:0] obs_q[$];
  int cyc, last_init_cyc, first_run_cyc, done_cyc;
  int run_seen, run_bursts, rst_seen, done_seen, err_seen, busy_seen;
  int stall_viol;
  logic prev_run, prev_valid;

  always @(posedge clk) prev_valid <= s_valid;

  always @(negedge clk) begin
    cyc++;
    if (pe_init != '0) begin
      obs_q.push_back({pe_init, pe_inst});
      last_init_cyc = cyc;
      if (!prev_valid) stall_viol++;
    end
    if (pe_run) begin
      run_seen++;
      if (!prev_run) run_bursts++;
      if (first_run_cyc < 0) first_run_cyc = cyc;
    end
    prev_run = pe_run;
    if (pe_rst) rst_seen++;
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (err) err_seen++;
    if (busy) busy_seen++;
  end

  task automatic clear_mon();
    @(posedge clk);
    obs_q.delete();
    last_init_cyc = -1;
    first_run_cyc = -1;
    done_cyc = -1;
    run_seen = 0;
    run_bursts = 0;
    rst_seen = 0;
    done_seen = 0;
    err_seen = 0;
    busy_seen = 0;
    stall_viol = 0;
  endtask

  task automatic pulse_start(input int nctx, input int rlen);
    @(negedge clk);
    start = 1'b1;
    num_ctx = NW'(nctx);
    run_len = RW'(rlen);
    @(negedge clk);
    start = 1'b0;
  endtask

  // vmode: 0 valid always, 1 toggling, 2 random.
  task automatic run_seq(input int nctx, input int rlen, input int vmode,
                         input bit directed, input bit mid_start,
                         input bit chk_bad, input int abort_at);
    logic [IW-1:0]     words[$];
    logic [NPE+IW-1:0] exp_q[$];
    logic [IW-1:0]     xsum;
    int total, idx, guard, exp_run;
    bit v, tog, acc, mid_done;

    total = NPE * nctx;
    xsum = '0;
    for (int i = 0; i < total; i++) begin
      if (directed) words.push_back(IW'(i + 1));
      else words.push_back(IW'({$urandom, $urandom}));
      xsum ^= words[i];
    end
    for (int p = 0; p < NPE; p++)
      for (int c = 0; c < nctx; c++)
        exp_q.push_back({NPE'(1 << p), words[p * nctx + c]});

    clear_mon();
    pulse_start(nctx, rlen);

    idx = 0;
    guard = 0;
    tog = 1'b1;
    mid_done = 1'b0;
    while (idx < total && guard < 4000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctrl_zero",
              64'({pe_rst, pe_run, busy, done, err, s_ready, pe_init}), 0);
        check("abort_inst_zero", 64'(pe_inst), 0);
        check("abort_init_count", 64'(obs_q.size()), 64'(abort_at));
        for (int i = 0; i < obs_q.size() && i < abort_at; i++)
          check("abort_init_word", 64'(obs_q[i]), 64'(exp_q[i]));
        rst = 1'b0;
        clear_mon();
        repeat (4) @(negedge clk);
        check("abort_no_strobes",
              64'(obs_q.size() + run_seen + done_seen + busy_seen), 0);
        return;
      end
      unique case (vmode)
        0: v = 1'b1;
        1: begin
          v = tog;
          tog = ~tog;
        end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      start = 1'b0;
      if (mid_start && idx == 2 && !mid_done) begin
        start = 1'b1;
        num_ctx = NW'(1);
        run_len = RW'(9);
        mid_done = 1'b1;
      end
      s_valid = v;
      s_data = words[idx];
      acc = v && s_ready;
      @(negedge clk);
      if (acc) idx++;
      guard++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (guard >= 4000) check("load_timeout", 0, 1);

`ifdef PE_CFG_CHECKSUM_EN
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 100) begin
      s_valid = 1'b1;
      s_data = xsum ^ IW'(chk_bad);
      acc = s_ready;
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0;
    if (!acc) check("chk_timeout", 0, 1);
`else
    if (chk_bad) check("chk_unsupported", 0, 1);
`endif

    guard = 0;
    while (done_seen == 0 && err_seen == 0 && guard < rlen + 30) begin
      @(negedge clk);
      guard++;
    end
    if (done_seen == 0 && err_seen == 0) check("end_timeout", 0, 1);
    repeat (5) @(negedge clk);

    exp_run = chk_bad ? 0 : rlen;
    check("init_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check("init_word", 64'(obs_q[i]), 64'(exp_q[i]));
    check("init_after_stall", 64'(stall_viol), 0);
    check("pe_rst_pulses", 64'(rst_seen), 1);
    check("run_cycles", 64'(run_seen), 64'(exp_run));
    check("run_bursts", 64'(run_bursts), 64'(exp_run > 0));
    if (exp_run > 0)
      check("run_after_init", 64'(first_run_cyc > last_init_cyc), 1);
    check("done_pulses", 64'(done_seen), 64'(!chk_bad));
    check("err_pulses", 64'(err_seen), 64'(chk_bad));
    check("busy_end", 64'(busy), 0);
    if (rlen == 0 && !chk_bad)
      check("done_latency",
            64'(done_cyc > last_init_cyc && done_cyc - last_init_cyc <= 2), 1);
  endtask

  task automatic bad_start(input int nctx);
    clear_mon();
    pulse_start(nctx, 5);
    check("err_next_cycle", 64'(err), 1);
    @(negedge clk);
    check("err_one_cycle", 64'(err), 0);
    repeat (3) @(negedge clk);
    check("err_count", 64'(err_seen), 1);
    check("err_busy_low", 64'(busy_seen), 0);
    check("err_no_pe_rst", 64'(rst_seen), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_ctx = '0;
    run_len = '0;
    s_data = '0;
    s_valid = 1'b0;
    prev_run = 1'b0;
    cyc = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl",
          64'({pe_rst, pe_run, busy, done, err, s_ready, pe_init}), 0);
    check("reset_inst", 64'(pe_inst), 0);
    rst = 1'b0;
    @(negedge clk);

    run_seq(2, 3, 0, 1'b1, 1'b0, 1'b0, -1);
    run_seq(2, 3, 1, 1'b1, 1'b0, 1'b0, -1);
    bad_start(0);
    bad_start(DEP + 1);
    run_seq(2, 3, 0, 1'b1, 1'b0, 1'b0, 3);
    run_seq(2, 3, 0, 1'b1, 1'b0, 1'b0, -1);
    run_seq(2, 0, 0, 1'b1, 1'b1, 1'b0, -1);
`ifdef PE_CFG_CHECKSUM_EN
    run_seq(2, 3, 0, 1'b1, 1'b0, 1'b0, -1);
    run_seq(2, 3, 0, 1'b1, 1'b0, 1'b1, -1);
`endif

    for (int k = 0; k < 12; k++) begin
      int nc, rl;
      bit ms, cb;
      nc = $urandom_range(1, 6);
      rl = $urandom_range(0, 6);
      ms = ($urandom_range(0, 1) == 1);
      cb = 1'b0;
`ifdef PE_CFG_CHECKSUM_EN
      cb = ($urandom_range(0, 3) == 0);
`endif
      run_seq(nc, rl, 2, 1'b0, ms, cb, -1);
    end
    run_seq(DEP, 2, 2, 1'b0, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
